// File: rtl/ob_table_cnt_csa_pipe_if.sv
// Handshake bundle for the pipelined carry-save word adder.
// The bench uses it to carry stimulus and results to the block.
interface ob_table_cnt_csa_pipe_if #(
  parameter int W = 32,
  parameter int N = 8
);
  logic         in_vld;
  logic [N*W-1:0] in_x;
  logic         in_rdy;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] s_w;
  logic [W-1:0] c_w;
  logic [W-1:0] sum_w;
  logic         busy;

  modport master (
    output in_vld, in_x, out_rdy,
    input  in_rdy, out_vld, s_w, c_w, sum_w, busy
  );

  modport slave (
    input  in_vld, in_x, out_rdy,
    output in_rdy, out_vld, s_w, c_w, sum_w, busy
  );
endinterface

// File: rtl/ob_table_cnt_csa_pipe.sv
// Pipelined 3:2 carry-save tree reducing N words to a sum/carry pair.
// Define OB_TABLE_CNT_CSA_PIPE_CPA_EN to add a carry-propagate stage.
module ob_table_cnt_csa_pipe #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_vld,
  input  logic [N*W-1:0] in_x,
  output logic           in_rdy,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic [W-1:0]   s_w,
  output logic [W-1:0]   c_w,
  output logic [W-1:0]   sum_w,
  output logic           busy
);

  function automatic int nxt_cnt(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int lvl_cnt(input int n);
    int l;
    int m;
    l = 0;
    m = n;
    while (m > 2) begin
      m = nxt_cnt(m);
      l++;
    end
    return l;
  endfunction

  function automatic int cnt_at(input int k);
    int m;
    m = N;
    for (int i = 0; i < k; i++) m = nxt_cnt(m);
    return m;
  endfunction

  localparam int L = lvl_cnt(N);
  localparam int D = (L < 1) ? 1 : L;
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
  localparam int T = D + 1;
`else
  localparam int T = D;
`endif

  logic [T-1:0] vld;
  logic [T-1:0] ld;
  logic         full_c;

  // Stage k may load unless it and every stage after it are full
  // while the consumer stalls.
  always_comb begin
    full_c = 1'b1;
    ld     = '0;
    for (int k = T - 1; k >= 0; k--) begin
      full_c = full_c & vld[k];
      ld[k]  = out_rdy | ~full_c;
    end
  end

  for (genvar k = 0; k < T; k++) begin : g_stg
    localparam int NI = cnt_at(k);
    localparam int NO = cnt_at(k + 1);
    localparam int NG = NI / 3;
    localparam int NR = NI % 3;

    logic [NI-1:0][W-1:0] li;
    logic [NO-1:0][W-1:0] dat_d;
    logic [NO-1:0][W-1:0] dat_q;
    logic                 vin;
    logic                 vld_q;

    if (k == 0) begin : g_head
      assign li  = in_x;
      assign vin = in_vld;
    end else begin : g_body
      assign li  = g_stg[k-1].dat_q;
      assign vin = vld[k-1];
    end

    always_comb begin
      dat_d = '0;
      for (int g = 0; g < NG; g++) begin
        dat_d[2*g] = li[3*g] ^ li[3*g+1] ^ li[3*g+2];
        dat_d[2*g+1] = ((li[3*g] & li[3*g+1])
                      | (li[3*g] & li[3*g+2])
                      | (li[3*g+1] & li[3*g+2])) << 1;
      end
      for (int j = 0; j < NR; j++) begin
        dat_d[2*NG+j] = li[3*NG+j];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (ld[k]) begin
        vld_q <= vin;
        if (vin) dat_q <= dat_d;
      end
    end

    assign vld[k] = vld_q;
  end

`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  assign sum_d = g_stg[D-1].dat_q[0] + g_stg[D-1].dat_q[1];

  // Rides alongside the delayed s/c pair in the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (ld[T-1] && vld[T-2]) begin
      sum_q <= sum_d;
    end
  end

  assign sum_w = sum_q;
`else
  assign sum_w = '0;
`endif

  assign s_w     = g_stg[T-1].dat_q[0];
  assign c_w     = g_stg[T-1].dat_q[1];
  assign out_vld = vld[T-1];
  assign busy    = |vld;
  assign in_rdy  = ld[0];

endmodule

// File: tb/tb_ob_table_cnt_csa_pipe.sv
// Bench for the carry-save pipeline: reference queue model
// plus directed beats with hand-computed sums.
module tb_ob_table_cnt_csa_pipe;
  localparam int W = 32;
  localparam int N = 8;
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
  localparam int CPA = 1;
`else
  localparam int CPA = 0;
`endif
  localparam int DEP = 4 + CPA;
  localparam int D8  = 4 + CPA;
  localparam int D2  = 1 + CPA;
  localparam int D3  = 1 + CPA;

  typedef struct {
    logic [W-1:0] sum;
    int           acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   nchk;
  int   nerr;
  int   nwait;

  exp_t         q[$];
  logic [W-1:0] got_q[$];

  ob_table_cnt_csa_pipe_if #(.W(W), .N(N)) bus ();

  ob_table_cnt_csa_pipe #(.W(W), .N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (bus.in_vld),
    .in_x   (bus.in_x),
    .in_rdy (bus.in_rdy),
    .out_vld(bus.out_vld),
    .out_rdy(bus.out_rdy),
    .s_w    (bus.s_w),
    .c_w    (bus.c_w),
    .sum_w  (bus.sum_w),
    .busy   (bus.busy)
  );

  logic        s_vld;
  logic [63:0] x8;
  logic [15:0] x2;
  logic [23:0] x3;
  logic        r8, r2, r3, b8, b2, b3;
  logic        o8_vld, o2_vld, o3_vld;
  logic [7:0]  o8_s, o8_c, o8_sum;
  logic [7:0]  o2_s, o2_c, o2_sum;
  logic [7:0]  o3_s, o3_c, o3_sum;

  ob_table_cnt_csa_pipe #(.W(8), .N(8)) d8 (
    .clk(clk), .rst(rst), .in_vld(s_vld), .in_x(x8),
    .in_rdy(r8), .out_vld(o8_vld), .out_rdy(1'b1),
    .s_w(o8_s), .c_w(o8_c), .sum_w(o8_sum), .busy(b8)
  );

  ob_table_cnt_csa_pipe #(.W(8), .N(2)) d2 (
    .clk(clk), .rst(rst), .in_vld(s_vld), .in_x(x2),
    .in_rdy(r2), .out_vld(o2_vld), .out_rdy(1'b1),
    .s_w(o2_s), .c_w(o2_c), .sum_w(o2_sum), .busy(b2)
  );

  ob_table_cnt_csa_pipe #(.W(8), .N(3)) d3 (
    .clk(clk), .rst(rst), .in_vld(s_vld), .in_x(x3),
    .in_rdy(r3), .out_vld(o3_vld), .out_rdy(1'b1),
    .s_w(o3_s), .c_w(o3_c), .sum_w(o3_sum), .busy(b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [W-1:0] wsum(input logic [N*W-1:0] x);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + x[i*W +: W];
    return s;
  endfunction

  function automatic logic [N*W-1:0] rep(input int k);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(k);
    return r;
  endfunction

  // Reference model: in-order queue of accepted beats.
  logic         stall_prev;
  logic [W-1:0] prev_s, prev_c, prev_sum;
  logic [W-1:0] sc;
  logic         exp_vld;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      exp_vld = (q.size() > 0) && (cyc - q[0].acc >= DEP);
      chk("out_vld", bus.out_vld, exp_vld);
      chk("busy", bus.busy, q.size() > 0);
      chk("in_rdy", bus.in_rdy,
          !(q.size() == DEP && !bus.out_rdy));
      if (stall_prev) begin
        chk("hold_vld", bus.out_vld, 1'b1);
        chk("hold_s", bus.s_w, prev_s);
        chk("hold_c", bus.c_w, prev_c);
        chk("hold_sum", bus.sum_w, prev_sum);
      end
      if (bus.out_vld && bus.out_rdy && q.size() > 0) begin
        sc = bus.s_w + bus.c_w;
        chk("s_plus_c", sc, q[0].sum);
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
        chk("sum_w", bus.sum_w, q[0].sum);
`else
        chk("sum_w_zero", bus.sum_w, '0);
`endif
        got_q.push_back(sc);
        void'(q.pop_front());
      end
      stall_prev = bus.out_vld && !bus.out_rdy;
      prev_s     = bus.s_w;
      prev_c     = bus.c_w;
      prev_sum   = bus.sum_w;
      if (bus.in_vld && bus.in_rdy) begin
        q.push_back('{sum: wsum(bus.in_x), acc: cyc});
      end
    end
  end

  task automatic send(input logic [N*W-1:0] x);
    bus.in_vld = 1'b1;
    bus.in_x   = x;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.in_rdy) break;
      nwait++;
    end
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
  endtask

  logic [N*W-1:0] v;
  logic [7:0]     t8;
  int             a;
  int             lat;
  int             acc;

  initial begin
    nchk = 0;
    nerr = 0;
    nwait = 0;
    cyc = 0;
    rst = 1'b1;
    bus.in_vld = 1'b0;
    bus.in_x = '0;
    bus.out_rdy = 1'b1;
    s_vld = 1'b0;
    x8 = '0;
    x2 = '0;
    x3 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_s", bus.s_w, '0);
    chk("rst_c", bus.c_w, '0);
    chk("rst_sum", bus.sum_w, '0);
    chk("rst_vld", bus.out_vld, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdy", bus.in_rdy, 1'b1);
    @(posedge clk);
    #1;

    // Words 1..8 and the latency to out_vld
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(i + 1);
    bus.in_vld = 1'b1;
    bus.in_x = v;
    @(negedge clk);
    chk("lat_rdy", bus.in_rdy, 1'b1);
    a = cyc;
    @(posedge clk);
    #1 bus.in_vld = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.out_vld) break;
    end
    lat = cyc - a;
    chk("latency", lat, DEP);
    sc = bus.s_w + bus.c_w;
    chk("sum36", sc, 36);
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
    chk("cpa36", bus.sum_w, 36);
`else
    chk("nocpa0", bus.sum_w, 0);
`endif
    @(posedge clk);
    #1;

    // Back-to-back beats k = 1..20
    got_q.delete();
    nwait = 0;
    for (int k = 1; k <= 20; k++) send(rep(k));
    chk("no_stall", nwait, 0);
    repeat (DEP + 3) @(posedge clk);
    #1;
    chk("stream_cnt", got_q.size(), 20);
    for (int i = 0; i < got_q.size(); i++) begin
      chk("stream_val", got_q[i], 8 * (i + 1));
    end

    // Consumer stall for 10 cycles with input held valid
    got_q.delete();
    acc = 0;
    bus.out_rdy = 1'b0;
    bus.in_vld = 1'b1;
    bus.in_x = rep(100);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (bus.in_rdy) acc++;
      @(posedge clk);
      #1 bus.in_x = rep(100 + acc);
    end
    bus.in_vld = 1'b0;
    chk("stall_acc", acc, DEP);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      @(negedge clk);
      chk("drain_vld", bus.out_vld, 1'b1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("drain_cnt", got_q.size(), DEP);
    for (int i = 0; i < got_q.size(); i++) begin
      chk("drain_val", got_q[i], 8 * (100 + i));
    end
    @(posedge clk);
    #1;

    // Small builds: W=8 all 0xFF, N=2 and N=3
    x8 = '1;
    x2 = {8'd7, 8'd5};
    x3 = {8'd3, 8'd2, 8'd1};
    s_vld = 1'b1;
    @(posedge clk);
    #1 s_vld = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      if (t == D2) begin
        chk("n2_vld", o2_vld, 1'b1);
        t8 = o2_s + o2_c;
        chk("n2_sum", t8, 12);
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
        chk("n2_cpa", o2_sum, 12);
`endif
      end
      if (t == D3) begin
        chk("n3_vld", o3_vld, 1'b1);
        t8 = o3_s + o3_c;
        chk("n3_sum", t8, 6);
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
        chk("n3_cpa", o3_sum, 6);
`endif
      end
      if (t == D8) begin
        chk("ff_vld", o8_vld, 1'b1);
        t8 = o8_s + o8_c;
        chk("ff_sum", t8, 8'hF8);
`ifdef OB_TABLE_CNT_CSA_PIPE_CPA_EN
        chk("ff_cpa", o8_sum, 8'hF8);
`endif
      end
    end
    @(posedge clk);
    #1;

    // Reset with three beats in flight, in_vld high during reset
    got_q.delete();
    for (int k = 1; k <= 3; k++) send(rep(50 + k));
    rst = 1'b1;
    bus.in_vld = 1'b1;
    bus.in_x = rep(77);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_vld = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_vld", bus.out_vld, 1'b0);
    chk("post_rst_rdy", bus.in_rdy, 1'b1);
    repeat (8) @(negedge clk);
    chk("post_rst_none", got_q.size(), 0);
    chk("post_rst_idle", bus.out_vld, 1'b0);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ob_table_cnt_csa_pipe.md
OB_TABLE_CNT_CSA_PIPE -- requirements
Module: ob_table_cnt_csa_pipe

Interface
REQ-001 SHALL have parameter W, default 32: width of each word in bits; legal values 2 to 64.
REQ-002 SHALL have parameter N, default 8: number of words summed per beat; legal values 2 to 32.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_vld, input, 1: input beat valid.
REQ-006 SHALL have port in_x, input, N x W: words to sum; word 0 occupies the least-significant W bits.
REQ-007 SHALL have port in_rdy, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port out_vld, output, 1: result valid.
REQ-009 SHALL have port out_rdy, input, 1: consumer accepts the result.
REQ-010 SHALL have port s_w, output, W: final unreduced sum vector.
REQ-011 SHALL have port c_w, output, W: final unreduced carry vector.
REQ-012 SHALL have port sum_w, output, W: carry-propagated sum; behaviour defined in Configuration.
REQ-013 SHALL have port busy, output, 1: high when any pipeline stage holds a valid beat.

Function
REQ-014 SHALL reduce N words to 2 through L levels of bitwise 3:2 compressors. Each level maps n words to 2*floor(n/3)+(n mod 3) words, with leftover words passed through unchanged. L is the level count needed to reach 2. Examples: N=8 gives L=4; N=3 gives L=1; N=2 gives L=0.
REQ-015 SHALL register the output of every compressor level; pipeline depth D = max(L,1), and N=2 uses one pass-through register stage.
REQ-016 SHALL compute each compressor as sum bit = a^b^c and carry bit = majority(a,b,c); the carry shifts left by one and bit 0 is zero.
REQ-017 SHALL discard any carry out of bit W-1; all arithmetic is modulo 2^W.
REQ-018 SHALL guarantee s_w + c_w == sum of all N words of the beat, modulo 2^W.
REQ-019 SHALL accept a beat on a cycle where in_vld && in_rdy; a result transfers on a cycle where out_vld && out_rdy.
REQ-020 SHALL give each stage k a valid bit; stage k loads when it is empty or stage k+1 loads (last stage: when out_rdy is high).
REQ-021 SHALL drive in_rdy as the load condition of stage 0; in_rdy has no combinational path from in_vld.
REQ-022 SHALL sustain one beat per cycle when out_rdy is held high; latency from acceptance to out_vld is D cycles.
REQ-023 SHALL hold out_vld, s_w, c_w and sum_w stable while out_vld && !out_rdy.
REQ-024 SHALL hold stalled stages and fill empty stages upstream of the first stalled stage (bubble collapse); no beat is dropped or duplicated, and order is preserved.
REQ-025 SHALL, on simultaneous acceptance and output transfer with a full pipeline, advance all stages in the same cycle.
REQ-026 SHALL not load data registers of a stage whose valid bit stays low (data don't-care, valid gated).

Reset
REQ-027 SHALL, while rst is high, clear all stage valid bits, so out_vld=0, busy=0 and in_rdy=1 on the first cycle after rst deasserts.
REQ-028 SHALL reset s_w, c_w and sum_w to 0.
REQ-029 SHALL, on rst asserted mid-operation, discard all in-flight beats; no result for them appears after reset.
REQ-030 SHALL ignore in_vld during any cycle with rst high.

Configuration
REQ-031 SHALL, with macro OB_TABLE_CNT_CSA_PIPE_CPA_EN defined, add one registered carry-propagate stage: sum_w = s_w + c_w mod 2^W. Depth becomes D+1, s_w and c_w are delayed to align with sum_w, and REQ-020 to REQ-025 apply to the added stage.
REQ-032 SHALL, with OB_TABLE_CNT_CSA_PIPE_CPA_EN undefined, tie sum_w to 0 and keep depth D.

Verification
REQ-033 W=32, N=8, out_rdy=1: single beat of words 1..8 -> out_vld exactly 4 cycles later with s_w+c_w=36; with CPA, 5 cycles later with sum_w=36.
REQ-034 W=8, N=8: all words 0xFF -> s_w+c_w mod 256 = 0xF8.
REQ-035 N=8, out_rdy=1: beats with all words set to k, for k=1..20 on consecutive cycles -> 20 results in order, each equal to 8k mod 2^W; in_rdy never deasserts.
REQ-036 Out_rdy held low for 10 cycles while in_vld=1 -> in_rdy falls after D beats accepted; on release, all D results emerge in order, one per cycle, with no gaps.
REQ-037 N=2 and N=3 builds: words {5,7} and {1,2,3} -> sums 12 and 6 after 1 cycle.
REQ-038 Rst pulsed 1 cycle with 3 beats in flight -> out_vld stays 0 until new input; busy=0 the cycle after reset.
